// File: rtl/serial_master_tx.sv
// Serial bus master transmitter: arbitrates for the bus, serialises slave select,
// header (address + burst) and write beats LSB first, with slave timeout and grant-loss abort.
module serial_master_tx #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cmd_write,
  input  logic [SLAVE_LEN-1:0] cmd_slave,
  input  logic [ADDR_LEN-1:0]  cmd_addr,
  input  logic [BURST_LEN-1:0] cmd_burst,
  input  logic [DATA_LEN-1:0]  wdata,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic                 approval_grant,
  input  logic                 busy,
  input  logic                 slave_ready,
  input  logic                 rx_done,
  output logic                 approval_request,
  output logic                 tx_slave_select,
  output logic                 tx_address,
  output logic                 tx_burst_number,
  output logic                 tx_data,
  output logic                 master_valid,
  output logic                 write_en,
  output logic                 read_en,
  output logic                 master_ready,
  output logic                 tx_done,
  output logic                 tx_error,
  output logic [1:0]           error_code,
  output logic [3:0]           debug_state
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] REQ        = 4'd1;
  localparam logic [3:0] SEL        = 4'd2;
  localparam logic [3:0] WAIT_SLAVE = 4'd3;
  localparam logic [3:0] HDR        = 4'd4;
  localparam logic [3:0] DATA_FETCH = 4'd5;
  localparam logic [3:0] DATA_SHIFT = 4'd6;
  localparam logic [3:0] READ_WAIT  = 4'd7;
  localparam logic [3:0] DONE       = 4'd8;

  localparam int HDR_LEN = (ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN;
  localparam int MAX_A   = (HDR_LEN > DATA_LEN) ? HDR_LEN : DATA_LEN;
  localparam int MAX_B   = (MAX_A > SLAVE_LEN) ? MAX_A : SLAVE_LEN;
  localparam int CNT_MAX = (MAX_B > TIMEOUT) ? MAX_B : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SLAVE_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);
  localparam logic [BURST_LEN:0] BEAT_ONE = (BURST_LEN + 1)'(1);

  logic [3:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic                 write_q;
  logic [SLAVE_LEN-1:0] slave_sr;
  logic [HDR_LEN-1:0]   addr_sr;
  logic [HDR_LEN-1:0]   burst_sr;
  logic [BURST_LEN-1:0] burst_q;
  logic [DATA_LEN-1:0]  data_sr;
  logic [BURST_LEN:0]   beats;
  logic [BURST_LEN:0]   beats_next;
  logic [BURST_LEN:0]   beat_target;
  logic                 abort;

  // A zero burst field still moves one beat; the extra counter bit lets an all-ones burst finish.
  assign beats_next  = beats + BEAT_ONE;
  assign beat_target = (burst_q == '0) ? BEAT_ONE : {1'b0, burst_q};
  assign abort       = !approval_grant &&
                       (state inside {SEL, WAIT_SLAVE, HDR, DATA_FETCH, DATA_SHIFT, READ_WAIT});

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      write_q    <= 1'b0;
      slave_sr   <= '0;
      addr_sr    <= '0;
      burst_sr   <= '0;
      burst_q    <= '0;
      data_sr    <= '0;
      beats      <= '0;
      tx_error   <= 1'b0;
      error_code <= 2'b00;
    end else begin
      tx_error <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        tx_error   <= 1'b1;
        error_code <= 2'b10;
      end else begin
        case (state)
          IDLE: begin
            if (start && !busy) begin
              write_q    <= cmd_write;
              slave_sr   <= cmd_slave;
              addr_sr    <= HDR_LEN'(cmd_addr);
              burst_sr   <= HDR_LEN'(cmd_burst);
              burst_q    <= cmd_burst;
              beats      <= '0;
              cnt        <= '0;
              error_code <= 2'b00;
              state      <= REQ;
            end
          end
          REQ: begin
            if (approval_grant) begin
              cnt   <= '0;
              state <= SEL;
            end
          end
          SEL: begin
            slave_sr <= slave_sr >> 1;
            if (cnt == SEL_LAST) begin
              cnt   <= '0;
              state <= WAIT_SLAVE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          WAIT_SLAVE: begin
            if (slave_ready) begin
              cnt   <= '0;
              state <= HDR;
            end else if (cnt == TO_LAST) begin
              tx_error   <= 1'b1;
              error_code <= 2'b01;
              state      <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          HDR: begin
            if (slave_ready) begin
              addr_sr  <= addr_sr >> 1;
              burst_sr <= burst_sr >> 1;
              if (cnt == HDR_LAST) begin
                cnt   <= '0;
                state <= write_q ? DATA_FETCH : READ_WAIT;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          DATA_FETCH: begin
            if (wdata_valid) begin
              data_sr <= wdata;
              cnt     <= '0;
              state   <= DATA_SHIFT;
            end
          end
          DATA_SHIFT: begin
            if (slave_ready) begin
              data_sr <= data_sr >> 1;
              if (cnt == DATA_LAST) begin
                cnt   <= '0;
                beats <= beats_next;
                state <= (beats_next == beat_target) ? DONE : DATA_FETCH;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          READ_WAIT: begin
            if (rx_done) state <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Status strobes are decoded from state so every exit path to IDLE drops them together.
  assign master_ready     = state inside {IDLE, REQ, SEL, WAIT_SLAVE};
  assign approval_request = state inside {REQ, SEL, WAIT_SLAVE, HDR, DATA_FETCH, DATA_SHIFT, READ_WAIT};
  assign write_en         = (state inside {HDR, DATA_FETCH, DATA_SHIFT, READ_WAIT}) && write_q;
  assign read_en          = (state inside {HDR, DATA_FETCH, DATA_SHIFT, READ_WAIT}) && !write_q;
  assign tx_slave_select  = (state == SEL) && slave_sr[0];
  assign tx_address       = (state == HDR) && addr_sr[0];
  assign tx_burst_number  = (state == HDR) && burst_sr[0];
  assign tx_data          = (state == DATA_SHIFT) && data_sr[0];
  assign master_valid     = (state == DATA_SHIFT);
  assign wdata_ready      = (state == DATA_FETCH);
  assign tx_done          = (state == DONE);
  assign debug_state      = state;

endmodule
